// File: rtl/dppl_pkg.sv
// Shared types for the multirate receive DPPL.
//   dpplState_t     : controller state (IDLE / ACQUIRE / LOCKED)
//   phaseDecision_t : per-edge phase correction chosen by the phase detector
package dppl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACQUIRE = 2'b01,
        LOCKED  = 2'b10
    } dpplState_t;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        RETARD  = 2'b01,
        ADVANCE = 2'b10
    } phaseDecision_t;

endpackage

// File: rtl/dppl_phase_detector.sv
// Combinational edge / phase classifier for the receive DPPL.
// Ports:
//   cnt           in  phase counter value in the current cycle
//   prevPos       in  posedge sample from the previous cycle
//   dpPosEdgeSync in  current posedge sample
//   dpNegEdgeSync in  sample from the preceding negedge
//   lineEdge      out line changed level this cycle
//   inTolerance   out cnt is within one cycle of the bit boundary
//   decision      out correction to apply if locked (NONE when no edge)
module dppl_phase_detector
    import dppl_pkg::*;
#(
    parameter  int OVERSAMPLE = 4,
    localparam int CW         = $clog2(OVERSAMPLE)
) (
    input  logic [CW-1:0]   cnt,
    input  logic            prevPos,
    input  logic            dpPosEdgeSync,
    input  logic            dpNegEdgeSync,
    output logic            lineEdge,
    output logic            inTolerance,
    output phaseDecision_t  decision
);

    localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    assign lineEdge    = (dpPosEdgeSync != prevPos);
    assign inTolerance = (cnt == LAST) || (cnt == '0) || (cnt == ONE);

    always_comb begin
        decision = NONE;
        if (lineEdge) begin
            if (cnt == '0) begin
                decision = NONE;
            end else if (cnt < HALF) begin
                decision = RETARD;
            end else if (cnt > HALF) begin
                decision = ADVANCE;
            end else begin
                // Exactly mid-bit: the negedge sample still showing the old
                // level means the transition happened late in the cycle.
                decision = (dpNegEdgeSync == prevPos) ? RETARD : ADVANCE;
            end
        end
    end

endmodule

// File: rtl/dppl_multirate.sv
// Multirate receive DPPL: recovers bit clock and bit value from an
// oversampled, synchronised line, with acquisition/lock tracking, +-1 cycle
// per-edge correction once locked, and an inactivity timeout.
// Ports:
//   clk48_i          in  oversampling clock
//   rstn_i           in  asynchronous active-low reset
//   enable_i         in  synchronous enable, low forces IDLE
//   dpPosEdgeSync_i  in  line sample from posedge
//   dpNegEdgeSync_i  in  line sample from the preceding negedge
//   readCLK_o        out recovered bit clock (phase counter upper half)
//   bitStrobe_o      out one-cycle pulse per recovered bit
//   rxBit_o          out recovered bit, valid with bitStrobe_o
//   DPPLGotSignal_o  out high in ACQUIRE and LOCKED
//   locked_o         out high in LOCKED
//
// state   | meaning
// IDLE    | line at idle level, counters cleared
// ACQUIRE | hard resync on every edge, counting in-tolerance edges
// LOCKED  | bounded +-1 cycle correction per edge
module dppl_multirate
    import dppl_pkg::*;
#(
    parameter int   OVERSAMPLE   = 4,
    parameter logic IDLE_LEVEL   = 1'b1,
    parameter int   LOCK_EDGES   = 3,
    parameter int   IDLE_TIMEOUT = 8
) (
    input  logic clk48_i,
    input  logic rstn_i,
    input  logic enable_i,
    input  logic dpPosEdgeSync_i,
    input  logic dpNegEdgeSync_i,
    output logic readCLK_o,
    output logic bitStrobe_o,
    output logic rxBit_o,
    output logic DPPLGotSignal_o,
    output logic locked_o
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int QW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CW-1:0] HALF        = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] ONE         = CW'(1);
    localparam logic [CW-1:0] TWO         = CW'(2);
    localparam logic [2:0]    LOCK_TARGET = 3'(LOCK_EDGES);
    localparam logic [QW-1:0] QUIET_LIMIT = QW'(IDLE_TIMEOUT);

    dpplState_t     state;
    logic [CW-1:0]  cnt;
    logic           prevPos;
    logic [2:0]     edgeCnt;
    logic [QW-1:0]  quietCnt;

    logic           lineEdge;
    logic           inTolerance;
    phaseDecision_t decision;
    logic           sampleNow;
    logic           timeout;
    logic [2:0]     nextEdgeCnt;

    dppl_phase_detector #(.OVERSAMPLE(OVERSAMPLE)) uPhaseDet (
        .cnt           (cnt),
        .prevPos       (prevPos),
        .dpPosEdgeSync (dpPosEdgeSync_i),
        .dpNegEdgeSync (dpNegEdgeSync_i),
        .lineEdge      (lineEdge),
        .inTolerance   (inTolerance),
        .decision      (decision)
    );

    assign readCLK_o   = cnt[CW-1];
    assign sampleNow   = enable_i && (state != IDLE) && (cnt == HALF);
    // quietCnt is checked one cycle after the strobe that filled it, so an
    // edge arriving in the strobe cycle still rescues the link.
    assign timeout     = (state != IDLE) && !lineEdge && (quietCnt == QUIET_LIMIT);
    assign nextEdgeCnt = inTolerance ? edgeCnt + 3'd1 : 3'd1;

    always_ff @(posedge clk48_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state           <= IDLE;
            cnt             <= '0;
            prevPos         <= IDLE_LEVEL;
            edgeCnt         <= '0;
            quietCnt        <= '0;
            bitStrobe_o     <= 1'b0;
            rxBit_o         <= 1'b0;
            DPPLGotSignal_o <= 1'b0;
            locked_o        <= 1'b0;
        end else begin
            prevPos     <= dpPosEdgeSync_i;
            bitStrobe_o <= sampleNow;
            rxBit_o     <= sampleNow & dpPosEdgeSync_i;
            if (!enable_i || timeout) begin
                state           <= IDLE;
                cnt             <= '0;
                edgeCnt         <= '0;
                quietCnt        <= '0;
                DPPLGotSignal_o <= 1'b0;
                locked_o        <= 1'b0;
            end else if (state == IDLE) begin
                cnt      <= '0;
                edgeCnt  <= '0;
                quietCnt <= '0;
                if (dpPosEdgeSync_i != IDLE_LEVEL) begin
                    state           <= ACQUIRE;
                    cnt             <= ONE;
                    edgeCnt         <= 3'd1;
                    DPPLGotSignal_o <= 1'b1;
                end
            end else if (lineEdge) begin
                quietCnt <= '0;
                if (state == LOCKED) begin
                    case (decision)
                        RETARD:  cnt <= cnt;
                        ADVANCE: cnt <= cnt + TWO;
                        default: cnt <= cnt + ONE;
                    endcase
                end else begin
                    cnt     <= ONE;
                    edgeCnt <= nextEdgeCnt;
                    if (nextEdgeCnt >= LOCK_TARGET) begin
                        state    <= LOCKED;
                        locked_o <= 1'b1;
                    end
                end
            end else begin
                cnt <= cnt + ONE;
                if (sampleNow) begin
                    quietCnt <= quietCnt + QW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dppl_multirate.sv
module tb_dppl_multirate;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4, en4, pos4, neg4;
    logic rclk4, st4, bit4, got4, lk4;
    logic rst8, en8, pos8, neg8;
    logic rclk8, st8, bit8, got8, lk8;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int s8    = 0;
    int   sCyc[$];
    logic sBit[$];
    logic expBits[$];

    dppl_multirate #(.OVERSAMPLE(4), .IDLE_LEVEL(1'b1), .LOCK_EDGES(3), .IDLE_TIMEOUT(8)) dut4 (
        .clk48_i(clk), .rstn_i(rst4), .enable_i(en4),
        .dpPosEdgeSync_i(pos4), .dpNegEdgeSync_i(neg4),
        .readCLK_o(rclk4), .bitStrobe_o(st4), .rxBit_o(bit4),
        .DPPLGotSignal_o(got4), .locked_o(lk4)
    );

    dppl_multirate #(.OVERSAMPLE(8), .IDLE_LEVEL(1'b1), .LOCK_EDGES(3), .IDLE_TIMEOUT(8)) dut8 (
        .clk48_i(clk), .rstn_i(rst8), .enable_i(en8),
        .dpPosEdgeSync_i(pos8), .dpNegEdgeSync_i(neg8),
        .readCLK_o(rclk8), .bitStrobe_o(st8), .rxBit_o(bit8),
        .DPPLGotSignal_o(got8), .locked_o(lk8)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            if (st4) begin
                sCyc.push_back(cyc);
                sBit.push_back(bit4);
            end
            if (st8) s8++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic line4(input logic v);
        pos4 = v;
        neg4 = v;
    endtask

    task automatic line8(input logic v);
        pos8 = v;
        neg8 = v;
    endtask

    task automatic sendBit4(input logic v, input int period);
        expBits.push_back(v);
        line4(v);
        tick(period);
    endtask

    task automatic clearLog();
        sCyc.delete();
        sBit.delete();
        expBits.delete();
    endtask

    // Every bit yields one strobe two cycles after it starts, carrying its value.
    task automatic checkStrobes(input string tag, input int period);
        check({tag, " count"}, sCyc.size(), expBits.size());
        for (int i = 0; i < expBits.size() && i < sCyc.size(); i++) begin
            check({tag, " bit"}, sBit[i], expBits[i]);
            if (i > 0) check({tag, " gap"}, sCyc[i] - sCyc[i-1], period);
        end
    endtask

    initial begin
        rst4 = 1'b0; en4 = 1'b1; line4(1'b1);
        rst8 = 1'b0; en8 = 1'b1; line8(1'b1);
        tick(3);
        check("rst readCLK", rclk4, 0);
        check("rst strobe", st4, 0);
        check("rst rxBit", bit4, 0);
        check("rst gotSignal", got4, 0);
        check("rst locked", lk4, 0);
        rst4 = 1'b1; rst8 = 1'b1;
        tick(2);
        check("idle stays idle", got4, 0);

        // Ideal 4 cycles/bit from idle.
        clearLog();
        expBits.push_back(1'b0);
        line4(1'b0);
        tick(1);
        check("acq gotSignal", got4, 1);
        check("acq not locked", lk4, 0);
        tick(3);
        sendBit4(1'b1, 4);
        check("lock after 2 edges", lk4, 0);
        expBits.push_back(1'b0);
        line4(1'b0);
        tick(1);
        check("lock after 3 edges", lk4, 1);
        tick(3);
        sendBit4(1'b1, 4); sendBit4(1'b0, 4); sendBit4(1'b1, 4); sendBit4(1'b1, 4);
        sendBit4(1'b0, 4); sendBit4(1'b0, 4); sendBit4(1'b1, 4);
        checkStrobes("ideal", 4);

        // Slow sender: 5 cycles/bit, retard on every edge.
        clearLog();
        for (int i = 0; i < 10; i++) sendBit4(logic'(i % 2), 5);
        checkStrobes("slow", 5);
        check("slow locked", lk4, 1);

        // Fast sender: 3 cycles/bit, advance on every edge.
        clearLog();
        for (int i = 0; i < 10; i++) sendBit4(logic'(i % 2), 3);
        checkStrobes("fast", 3);
        check("fast locked", lk4, 1);

        // Reset mid-packet, asserted while a strobe is showing.
        sendBit4(1'b0, 4);
        line4(1'b1);
        tick(3);
        check("pre-reset strobe", st4, 1);
        rst4 = 1'b0;
        #1;
        check("midrst strobe", st4, 0);
        check("midrst rxBit", bit4, 0);
        check("midrst gotSignal", got4, 0);
        check("midrst locked", lk4, 0);
        check("midrst readCLK", rclk4, 0);
        tick(2);
        rst4 = 1'b1;
        tick(1);
        check("post-rst idle", got4, 0);
        line4(1'b0);
        tick(1);
        check("post-rst reacq", got4, 1);
        tick(3);
        line4(1'b1); tick(4);
        line4(1'b0); tick(4);
        check("relock", lk4, 1);

        // One-cycle enable drop.
        en4 = 1'b0;
        tick(1);
        check("dis gotSignal", got4, 0);
        check("dis locked", lk4, 0);
        check("dis strobe", st4, 0);
        check("dis readCLK", rclk4, 0);
        en4 = 1'b1;
        tick(1);
        check("en reacq", got4, 1);
        check("en not locked", lk4, 0);

        // Acquisition with an out-of-tolerance edge at k=2.
        rst4 = 1'b0; line4(1'b1); tick(2);
        rst4 = 1'b1; tick(2);
        line4(1'b0); tick(2);
        line4(1'b1); tick(4);
        line4(1'b0); tick(1);
        check("glitch restart", lk4, 0);
        tick(3);
        line4(1'b1); tick(1);
        check("glitch relock", lk4, 1);

        // OVERSAMPLE=8 timeout after 8 quiet strobes.
        line8(1'b0); tick(8);
        line8(1'b1); tick(8);
        line8(1'b0); tick(1);
        check("os8 locked", lk8, 1);
        s8 = 0;
        tick(59);
        check("os8 quiet 7", s8, 7);
        check("os8 still locked", lk8, 1);
        tick(1);
        check("os8 8th strobe", st8, 1);
        tick(1);
        check("timeout locked", lk8, 0);
        check("timeout gotSignal", got8, 0);

        // Same, but an edge lands in the 8th strobe cycle.
        rst8 = 1'b0; line8(1'b1); tick(2);
        rst8 = 1'b1; tick(2);
        line8(1'b0); tick(8);
        line8(1'b1); tick(8);
        line8(1'b0); tick(1);
        tick(59);
        tick(1);
        check("rescue 8th strobe", st8, 1);
        line8(1'b1);
        tick(1);
        check("rescue locked", lk8, 1);
        check("rescue gotSignal", got8, 1);
        tick(4);
        check("rescue hold", lk8, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
